// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per handshake as start, 8 data bits LSB first, optional even parity, 1-2 stop bits.
// Latency: tx drops to the start level on the edge after the handshake; a frame lasts P_CLKS_PER_BIT*(9+parity+stops) cycles.
// Backpressure: ready is high only while idle; valid is ignored for the whole frame, including while done pulses.
module uart_tx #(
  parameter int P_CLKS_PER_BIT = 16,
  parameter int P_PARITY_EN    = 0,
  parameter int P_STOP_BITS    = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] data_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // A counter of width 1 still covers the smallest legal bit time of 2 cycles.
  localparam int              CNT_W     = (P_CLKS_PER_BIT > 1) ? $clog2(P_CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_CLKS_PER_BIT - 1);
  // Stop-bit index at which the frame ends (0 for one stop bit, 1 for two).
  localparam logic             STOP_LAST = (P_STOP_BITS == 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             stop_q, stop_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic; tx_d is the line level of the cycle the next state begins.
  // The shift register rotates rather than shifts, so after eight bits it
  // holds the original byte again and its XOR is the parity bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    shift_d = shift_q;
    stop_d  = stop_q;
    tx_d    = tx_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (valid) begin
          shift_d = data_in;
          idx_d   = '0;
          stop_d  = 1'b0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          shift_d = {shift_q[0], shift_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d = '0;
            if (P_PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = ^shift_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = ~ready;
  assign tx    = tx_q;
  assign done  = (state_q == S_STOP) && bit_end && (stop_q == STOP_LAST);

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [3:0] valid_v;
  logic [3:0] ready_v;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [7:0] din0, din1, din2, din3;

  int checks;
  int errors;
  bit exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d0: 4 clk/bit, no parity, 1 stop; d1: parity; d2: 2 stops; d3: 2 clk/bit, parity, 2 stops
  uart_tx #(.P_CLKS_PER_BIT(4), .P_PARITY_EN(0), .P_STOP_BITS(1)) d0 (
    .CLK(clk), .RST(rst), .data_in(din0), .valid(valid_v[0]), .ready(ready_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx #(.P_CLKS_PER_BIT(4), .P_PARITY_EN(1), .P_STOP_BITS(1)) d1 (
    .CLK(clk), .RST(rst), .data_in(din1), .valid(valid_v[1]), .ready(ready_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx #(.P_CLKS_PER_BIT(4), .P_PARITY_EN(0), .P_STOP_BITS(2)) d2 (
    .CLK(clk), .RST(rst), .data_in(din2), .valid(valid_v[2]), .ready(ready_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx #(.P_CLKS_PER_BIT(2), .P_PARITY_EN(1), .P_STOP_BITS(2)) d3 (
    .CLK(clk), .RST(rst), .data_in(din3), .valid(valid_v[3]), .ready(ready_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  function automatic int clks_of(input int k);
    return (k == 3) ? 2 : 4;
  endfunction

  function automatic int par_of(input int k);
    return (k == 1 || k == 3) ? 1 : 0;
  endfunction

  function automatic int stops_of(input int k);
    return (k == 2 || k == 3) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_din(input int k, input logic [7:0] d);
    case (k)
      0: din0 = d;
      1: din1 = d;
      2: din2 = d;
      default: din3 = d;
    endcase
  endtask

  // Reference frame as a list of serial bit levels, one entry per bit time.
  task automatic build(input int k, input logic [7:0] d);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(d[i]);
      ones += d[i];
    end
    if (par_of(k) != 0) exp_q.push_back((ones % 2) == 1);
    for (int i = 0; i < stops_of(k); i++) exp_q.push_back(1'b1);
  endtask

  // Called at a negedge with the instance idle. Presents d, then checks up to
  // ncyc cycles of the frame (all of it when ncyc < 0). With hold set, valid
  // stays high through the frame, so the next call forms a back-to-back frame.
  task automatic send(input int k, input logic [7:0] d, input bit hold, input int ncyc);
    int len;
    int p;
    p = clks_of(k);
    set_din(k, d);
    valid_v[k] = 1'b1;
    chk($sformatf("ready_before_hs k%0d", k), 32'(ready_v[k]), 32'd1);
    build(k, d);
    len = exp_q.size() * p;
    if (ncyc >= 0 && ncyc < len) len = ncyc;
    @(negedge clk);
    if (!hold) valid_v[k] = 1'b0;
    for (int c = 0; c < len; c++) begin
      chk($sformatf("tx k%0d d%02h c%0d", k, d, c), 32'(tx_v[k]), 32'(exp_q[c / p]));
      chk($sformatf("done k%0d d%02h c%0d", k, d, c), 32'(done_v[k]),
          32'(c == exp_q.size() * p - 1));
      chk($sformatf("busy k%0d c%0d", k, c), 32'(busy_v[k]), 32'd1);
      chk($sformatf("ready k%0d c%0d", k, c), 32'(ready_v[k]), 32'd0);
      set_din(k, 8'($urandom));
      @(negedge clk);
    end
    if (ncyc < 0) begin
      chk($sformatf("idle_ready k%0d", k), 32'(ready_v[k]), 32'd1);
      chk($sformatf("idle_tx k%0d", k), 32'(tx_v[k]), 32'd1);
      chk($sformatf("idle_done k%0d", k), 32'(done_v[k]), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s tx k%0d", tag, k), 32'(tx_v[k]), 32'd1);
      chk($sformatf("%s ready k%0d", tag, k), 32'(ready_v[k]), 32'd1);
      chk($sformatf("%s busy k%0d", tag, k), 32'(busy_v[k]), 32'd0);
      chk($sformatf("%s done k%0d", tag, k), 32'(done_v[k]), 32'd0);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    valid_v = 4'b0000;
    din0 = 8'h00; din1 = 8'h00; din2 = 8'h00; din3 = 8'h00;

    // Reset values before any clock edge, then after edges under reset
    #1;
    chk_reset_outputs("reset_noclk");
    @(negedge clk);
    chk_reset_outputs("reset_clk");
    rst = 1'b0;

    // 0xA5, 4 clk/bit: first handshake on the first edge after reset release
    send(0, 8'hA5, 1'b0, -1);

    // Parity: 0x07 gives parity 1, 0x03 gives parity 0
    send(1, 8'h07, 1'b0, -1);
    send(1, 8'h03, 1'b0, -1);

    // Two stop bits with 0xFF
    send(2, 8'hFF, 1'b0, -1);

    // Back-to-back with valid held high and data scrambled mid-frame
    send(0, 8'h55, 1'b1, -1);
    send(0, 8'hAA, 1'b0, -1);

    // Smallest bit time
    send(3, 8'h96, 1'b0, -1);

    // Random bytes on every configuration
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        send(k, 8'($urandom_range(0, 255)), 1'b0, -1);
      end
    end

    // Reset mid-frame: 10 cycles into a 0x00 frame, then async reset
    send(0, 8'h00, 1'b0, 10);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midframe_rst");
    @(negedge clk);
    chk_reset_outputs("midframe_rst_hold");
    rst = 1'b0;
    send(0, 8'h3C, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute bound so the run always ends even if the sequence stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
